// File: rtl/fm_modulator.sv
// fm_modulator: FM transmit path. Signed audio samples are integrated into a
// phase accumulator; each phase is mapped through a quarter-wave sine LUT and
// emitted as an interleaved I (cos) then Q (sin) byte stream.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   start_i  enable; when low no new samples are accepted
//   data_i   signed 8-bit audio sample
//   valid_i  data_i valid
//   ready_o  combinational; sample accepted on edge where valid_i && ready_o
//   data_o   registered signed I or Q byte
//   valid_o  registered data_o valid
//   iq_o     registered, 0 = I (cos), 1 = Q (sin)
module fm_modulator #(
    parameter int unsigned PHASE_W  = 16,
    parameter int unsigned KF_SHIFT = 6,
    parameter int          FREQ_OFS = 0,
    parameter int unsigned LUT_AW   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       iq_o
);

    localparam int unsigned QW = LUT_AW - 2;
    localparam int unsigned QN = 1 << QW;

    // First quadrant of round(127*sin(2*pi*n/256)), n = 0..64. The array
    // bound ties the table to LUT_AW = 8; another width fails elaboration.
    localparam logic [6:0] SINE_Q [0:QN] = '{
        7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
        7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
        7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
        7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
        7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
        7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
        7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127,
        7'd127
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EMIT_I = 2'd1,
        EMIT_Q = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] phase_inc;
    logic [LUT_AW-1:0]  k_q;
    logic [LUT_AW-1:0]  k_i;
    logic [7:0]         cos_v;
    logic [7:0]         sin_v;
    logic [7:0]         data_nxt;
    logic               valid_nxt;
    logic               iq_nxt;
    logic               accept;

    // Full-wave sine from the quarter table: odd quadrants mirror the index,
    // the upper half-wave negates the magnitude.
    function automatic logic [7:0] lut_sin(input logic [LUT_AW-1:0] k);
        logic [QW-1:0] idx;
        logic [QW:0]   addr;
        logic [6:0]    mag;
        idx  = k[QW-1:0];
        addr = k[QW] ? ((QW+1)'(QN) - {1'b0, idx}) : {1'b0, idx};
        mag  = SINE_Q[addr];
        return k[LUT_AW-1] ? 8'(8'd0 - {1'b0, mag}) : {1'b0, mag};
    endfunction

    assign accept    = valid_i && ready_o;
    assign phase_inc = PHASE_W'({{(PHASE_W-8){data_i[7]}}, data_i} << KF_SHIFT)
                     + PHASE_W'(FREQ_OFS);
    assign k_q       = phase[PHASE_W-1 -: LUT_AW];
    assign k_i       = k_q + LUT_AW'(QN);
    assign cos_v     = lut_sin(k_i);
    assign sin_v     = lut_sin(k_q);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? EMIT_I : IDLE;
            EMIT_I:  state_nxt = EMIT_Q;
            EMIT_Q:  state_nxt = accept ? EMIT_I : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: ready and next values for the output registers
    always_comb begin
        ready_o   = 1'b0;
        valid_nxt = 1'b0;
        iq_nxt    = 1'b0;
        data_nxt  = cos_v;
        case (state)
            IDLE: begin
                ready_o = start_i && !rst;
            end
            EMIT_I: begin
                valid_nxt = 1'b1;
                data_nxt  = cos_v;
            end
            EMIT_Q: begin
                ready_o   = start_i && !rst;
                valid_nxt = 1'b1;
                iq_nxt    = 1'b1;
                data_nxt  = sin_v;
            end
            default: begin
                ready_o = 1'b0;
            end
        endcase
    end

    // Phase accumulator; wraps modulo 2^PHASE_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
        end else if (accept) begin
            phase <= phase + phase_inc;
        end
    end

    // Output registers; data/iq hold while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_o  <= '0;
            valid_o <= 1'b0;
            iq_o    <= 1'b0;
        end else begin
            valid_o <= valid_nxt;
            if (valid_nxt) begin
                data_o <= data_nxt;
                iq_o   <= iq_nxt;
            end
        end
    end

endmodule

// File: tb/tb_fm_modulator.sv
// Self-checking bench for fm_modulator: directed and random samples checked
// against a trigonometric reference model and an expected-byte queue.
module tb_fm_modulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] data_o;
    logic       valid_o;
    logic       iq_o;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_phase;
    logic        m_acc;
    logic [7:0]  m_last_d;
    logic        m_last_iq;
    logic [7:0]  exp_d[$];
    logic        exp_iq[$];
    logic [7:0]  got[$];

    fm_modulator dut (
        .clk    (clk),
        .rst    (rst),
        .start_i(start_i),
        .data_i (data_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .data_o (data_o),
        .valid_o(valid_o),
        .iq_o   (iq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // round(127*sin(2*pi*n/256)) as a two's complement byte
    function automatic logic [7:0] s_ref(input int n);
        real r;
        r = 127.0 * $sin(2.0 * 3.141592653589793 * real'(n) / 256.0);
        if (r >= 0.0) return 8'($rtoi(r + 0.5));
        return 8'(-$rtoi(-r + 0.5));
    endfunction

    task automatic model_accept(input logic [7:0] d);
        int k;
        m_phase = m_phase + 16'($signed(d) * 64);
        k = int'(m_phase[15:8]);
        exp_d.push_back(s_ref((k + 64) % 256));
        exp_iq.push_back(1'b0);
        exp_d.push_back(s_ref(k));
        exp_iq.push_back(1'b1);
    endtask

    // One clock: drive inputs, check ready, clock, check outputs
    task automatic step(input logic v, input logic [7:0] d, input logic s, output logic acc);
        logic       exp_rdy;
        logic [7:0] ed;
        logic       ei;
        valid_i = v;
        data_i  = d;
        start_i = s;
        #1;
        exp_rdy = s && !m_acc;
        chk("ready_o", 16'(ready_o), 16'(exp_rdy));
        acc = v && exp_rdy;
        @(posedge clk);
        #1;
        if (exp_d.size() > 0) begin
            ed = exp_d.pop_front();
            ei = exp_iq.pop_front();
            chk("valid_o", 16'(valid_o), 16'd1);
            chk("data_o", 16'(data_o), 16'(ed));
            chk("iq_o", 16'(iq_o), 16'(ei));
            m_last_d  = ed;
            m_last_iq = ei;
            got.push_back(data_o);
        end else begin
            chk("valid_o_idle", 16'(valid_o), 16'd0);
            chk("data_o_hold", 16'(data_o), 16'(m_last_d));
            chk("iq_o_hold", 16'(iq_o), 16'(m_last_iq));
        end
        m_acc = acc;
        if (acc) model_accept(d);
    endtask

    task automatic send(input logic [7:0] d);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 4 && !acc; t++) step(1'b1, d, 1'b1, acc);
        if (!acc) chk("send_timeout", 16'd0, 16'd1);
    endtask

    task automatic drain();
        logic acc;
        for (int t = 0; t < 8 && exp_d.size() > 0; t++) step(1'b0, 8'd0, 1'b1, acc);
        chk("drain_empty", 16'(exp_d.size()), 16'd0);
        step(1'b0, 8'd0, 1'b1, acc);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        valid_i = 1'b0;
        start_i = 1'b1;
        data_i  = 8'd0;
        #1;
        chk("rst_valid_o", 16'(valid_o), 16'd0);
        chk("rst_data_o", 16'(data_o), 16'd0);
        chk("rst_iq_o", 16'(iq_o), 16'd0);
        chk("rst_ready_o", 16'(ready_o), 16'd0);
        exp_d.delete();
        exp_iq.delete();
        got.delete();
        m_phase   = 16'd0;
        m_acc     = 1'b0;
        m_last_d  = 8'd0;
        m_last_iq = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_ready_hold", 16'(ready_o), 16'd0);
        rst = 1'b0;
    endtask

    task automatic chk_got(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input int idx);
        logic [7:0] g0;
        logic [7:0] g1;
        g0 = (got.size() > idx)     ? got[idx]     : 8'hxx;
        g1 = (got.size() > idx + 1) ? got[idx + 1] : 8'hxx;
        chk({tag, "_i"}, 16'(g0), 16'(e0));
        chk({tag, "_q"}, 16'(g1), 16'(e1));
    endtask

    initial begin
        logic acc;
        rst     = 1'b1;
        start_i = 1'b0;
        valid_i = 1'b0;
        data_i  = 8'd0;

        do_reset();

        // DC zero: continuous valid, stream 127,0,127,0...
        for (int i = 0; i < 12; i++) step(1'b1, 8'd0, 1'b1, acc);
        chk_got("dc0", 8'd127, 8'd0, 0);
        chk_got("dc1", 8'd127, 8'd0, 2);

        // Reset mid-stream, then first pair restarts from phase 0
        do_reset();
        send(8'd64);
        drain();
        chk_got("rst_restart", 8'd117, 8'd49, 0);
        chk("rst_restart_phase", dut.phase, 16'h1000);

        // Positive step: four samples of +64
        do_reset();
        for (int i = 0; i < 4; i++) send(8'd64);
        drain();
        chk_got("pos0", 8'd117, 8'd49, 0);
        chk_got("pos1", 8'd90, 8'd90, 2);
        chk_got("pos2", 8'd49, 8'd117, 4);
        chk_got("pos3", 8'd0, 8'd127, 6);
        chk("pos_phase", dut.phase, 16'h4000);

        // Negative wrap: -64 then +64
        do_reset();
        send(8'hC0);
        chk("neg_phase", dut.phase, 16'hF000);
        send(8'd64);
        drain();
        chk_got("neg0", 8'd117, 8'hCF, 0);
        chk_got("neg1", 8'd127, 8'd0, 2);
        chk("neg_phase_back", dut.phase, 16'h0000);

        // Back-to-back random samples
        do_reset();
        for (int i = 0; i < 100; i++) send(8'($urandom));
        drain();
        chk("b2b_bytes", 16'(got.size()), 16'd200);

        // Random gaps in valid_i and start_i
        for (int i = 0; i < 80; i++)
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0), acc);
        drain();

        // start_i drop during EMIT_I: pair completes, no accepts, phase kept
        send(8'd37);
        for (int i = 0; i < 5; i++) step(1'b1, 8'd99, 1'b0, acc);
        chk("drop_phase", dut.phase, m_phase);
        send(8'hF3);
        drain();
        chk("end_phase", dut.phase, m_phase);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
